// File: rtl/vx_axi_req_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_axi_req_scheduler_pkg
// Description : Shared AXI burst constants and ID field width helpers for the
//               Vortex memory-port to AXI request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_axi_req_scheduler_pkg;

   // Every transfer is a single beat incrementing burst
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // log2 of the bytes per data beat, used for awsize/arsize and address shift
   function automatic int axi_size_log2(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Width of the port-index field carried in the low bits of the AXI ID
   function automatic int port_field_width(input int num_reqs);
      return (num_reqs > 1) ? $clog2(num_reqs) : 1;
   endfunction

   // Full AXI ID width: {tag, port index}
   function automatic int id_width(input int tag_width, input int num_reqs);
      return tag_width + port_field_width(num_reqs);
   endfunction

endpackage : vx_axi_req_scheduler_pkg
`default_nettype wire

// File: rtl/vx_axi_req_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_axi_req_scheduler_if
// Description : Single-beat AXI4 master bus (AW/W/B/AR/R) used between the
//               request scheduler and the downstream AXI bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface vx_axi_req_scheduler_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 9
);
   // write address channel
   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [ID_WIDTH-1:0]     awid;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   // write data channel
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   // write response channel
   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   // read address channel
   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [ID_WIDTH-1:0]     arid;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   // read data channel
   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [ID_WIDTH-1:0]     rid;
   logic [1:0]              rresp;
   logic                    rlast;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rid, rresp, rlast,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rid, rresp, rlast,
      input  rready
   );

endinterface : vx_axi_req_scheduler_if
`default_nettype wire

// File: rtl/vx_axi_req_scheduler_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : vx_rr_grant
// Description : Round-robin one-hot grant. The search starts one past the
//               last granted index; the pointer only moves when the grant is
//               actually consumed (advance).
// Revision    : 1.0 - initial release
// ============================================================================
module vx_rr_grant #(
   parameter int NUM_REQS  = 2,
   parameter int IDX_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQS-1:0]  req,
   input  logic                 advance,
   output logic [NUM_REQS-1:0]  grant,
   output logic [IDX_WIDTH-1:0] grant_idx,
   output logic                 grant_valid
);

   logic [IDX_WIDTH-1:0] rr_ptr;
   int                   search_idx;

   // First requester found scanning from rr_ptr+1 wrapping around
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      search_idx  = 0;
      for (int k = 1; k <= NUM_REQS; k++) begin
         search_idx = (int'(rr_ptr) + k) % NUM_REQS;
         if (!grant_valid && req[search_idx]) begin
            grant[search_idx] = 1'b1;
            grant_idx         = IDX_WIDTH'(search_idx);
            grant_valid       = 1'b1;
         end
      end
   end

   // Remember the last winner so it gets lowest priority next time
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
      end else if (advance && grant_valid) begin
         rr_ptr <= grant_idx;
      end
   end

endmodule : vx_rr_grant
`default_nettype wire

// File: rtl/vx_axi_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vx_axi_req_scheduler
// Description : Shares one AXI4 master between NUM_REQS Vortex memory ports.
//               Round-robin arbitration feeds a one-entry issue register that
//               drives AW+W or AR; credit counters bound outstanding reads and
//               writes; R beats are routed back by the port index in the ID.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_axi_req_scheduler
   import vx_axi_req_scheduler_pkg::*;
#(
   parameter int NUM_REQS       = 2,
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH_IN  = 26,
   parameter int ADDR_WIDTH_OUT = 32,
   parameter int TAG_WIDTH      = 8,
   parameter int MAX_PENDING    = 16,
   parameter int ID_WIDTH       = id_width(TAG_WIDTH, NUM_REQS)
) (
   input  logic                      clk,
   input  logic                      reset_n,

   input  logic [NUM_REQS-1:0]       mem_req_valid,
   input  logic [NUM_REQS-1:0]       mem_req_rw,
   input  logic [ADDR_WIDTH_IN-1:0]  mem_req_addr   [NUM_REQS],
   input  logic [DATA_WIDTH/8-1:0]   mem_req_byteen [NUM_REQS],
   input  logic [DATA_WIDTH-1:0]     mem_req_data   [NUM_REQS],
   input  logic [TAG_WIDTH-1:0]      mem_req_tag    [NUM_REQS],
   output logic [NUM_REQS-1:0]       mem_req_ready,

   output logic [NUM_REQS-1:0]       mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]     mem_rsp_data   [NUM_REQS],
   output logic [TAG_WIDTH-1:0]      mem_rsp_tag    [NUM_REQS],
   input  logic [NUM_REQS-1:0]       mem_rsp_ready,

   vx_axi_req_scheduler_if.master    axi,

   output logic                      busy,
   output logic                      error
);

   localparam int SIZE_LOG2   = axi_size_log2(DATA_WIDTH);
   localparam int PORT_W      = port_field_width(NUM_REQS);
   localparam int CNT_W       = $clog2(MAX_PENDING + 1);
   localparam int FULL_ADDR_W = ADDR_WIDTH_IN + SIZE_LOG2;
   localparam int WIDE_ADDR_W = (FULL_ADDR_W > ADDR_WIDTH_OUT) ? FULL_ADDR_W : ADDR_WIDTH_OUT;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // credit counters
   logic [CNT_W-1:0]          rd_cnt;
   logic [CNT_W-1:0]          wr_cnt;
   logic                      rd_room;
   logic                      wr_room;

   // arbitration
   logic [NUM_REQS-1:0]       eligible;
   logic [NUM_REQS-1:0]       grant;
   logic [PORT_W-1:0]         grant_idx;
   logic                      grant_valid;
   logic                      req_fire;
   logic                      req_is_wr;

   // selected request, formatted for AXI
   logic [FULL_ADDR_W-1:0]    sel_addr_full;
   logic [WIDE_ADDR_W-1:0]    sel_addr_wide;
   logic [ADDR_WIDTH_OUT-1:0] sel_addr;
   logic [ID_WIDTH-1:0]       sel_id;

   // issue register
   logic                      iss_aw;
   logic                      iss_w;
   logic                      iss_ar;
   logic                      iss_empty;
   logic [ADDR_WIDTH_OUT-1:0] iss_addr;
   logic [ID_WIDTH-1:0]       iss_id;
   logic [DATA_WIDTH-1:0]     iss_data;
   logic [DATA_WIDTH/8-1:0]   iss_strb;

   // response side
   logic [PORT_W-1:0]         rsp_port;
   logic                      rsp_port_ok;
   logic                      rd_inc;
   logic                      rd_dec;
   logic                      wr_inc;
   logic                      wr_dec;
   logic                      err_evt;

   logic                      unused_sigs;

   assign rd_room = (rd_cnt < CNT_MAX);
   assign wr_room = (wr_cnt < CNT_MAX);

   // A port competes only if the counter for its request type has room
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         eligible[i] = mem_req_valid[i] && (mem_req_rw[i] ? wr_room : rd_room);
      end
   end

   vx_rr_grant #(
      .NUM_REQS  (NUM_REQS),
      .IDX_WIDTH (PORT_W)
   ) u_rr_grant (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (eligible),
      .advance     (req_fire),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Ready uses the registered empty flag, so a refill waits one cycle after draining
   assign iss_empty     = !(iss_aw || iss_w || iss_ar);
   assign mem_req_ready = iss_empty ? grant : '0;
   assign req_fire      = grant_valid && iss_empty;
   assign req_is_wr     = mem_req_rw[grant_idx];

   // Line address to byte address, then fit to the AXI address width
   always_comb begin
      sel_addr_full = FULL_ADDR_W'(mem_req_addr[grant_idx]) << SIZE_LOG2;
      sel_addr_wide = WIDE_ADDR_W'(sel_addr_full);
      sel_addr      = sel_addr_wide[ADDR_WIDTH_OUT-1:0];
      sel_id        = ID_WIDTH'({mem_req_tag[grant_idx], grant_idx});
   end

   // Issue register: load on request fire, drop each channel valid on its handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_aw   <= 1'b0;
         iss_w    <= 1'b0;
         iss_ar   <= 1'b0;
         iss_addr <= '0;
         iss_id   <= '0;
         iss_data <= '0;
         iss_strb <= '0;
      end else if (req_fire) begin
         iss_aw   <= req_is_wr;
         iss_w    <= req_is_wr;
         iss_ar   <= !req_is_wr;
         iss_addr <= sel_addr;
         iss_id   <= sel_id;
         iss_data <= mem_req_data[grant_idx];
         iss_strb <= mem_req_byteen[grant_idx];
      end else begin
         if (iss_aw && axi.awready) iss_aw <= 1'b0;
         if (iss_w  && axi.wready)  iss_w  <= 1'b0;
         if (iss_ar && axi.arready) iss_ar <= 1'b0;
      end
   end

   assign axi.awvalid = iss_aw;
   assign axi.awaddr  = iss_addr;
   assign axi.awid    = iss_id;
   assign axi.awlen   = AXI_LEN_SINGLE;
   assign axi.awsize  = 3'(SIZE_LOG2);
   assign axi.awburst = AXI_BURST_INCR;
   assign axi.wvalid  = iss_w;
   assign axi.wdata   = iss_data;
   assign axi.wstrb   = iss_strb;
   assign axi.wlast   = 1'b1;
   assign axi.bready  = 1'b1;
   assign axi.arvalid = iss_ar;
   assign axi.araddr  = iss_addr;
   assign axi.arid    = iss_id;
   assign axi.arlen   = AXI_LEN_SINGLE;
   assign axi.arsize  = 3'(SIZE_LOG2);
   assign axi.arburst = AXI_BURST_INCR;

   // Out-of-range port field is absorbed (rready=1) and flagged as an error
   assign rsp_port    = axi.rid[PORT_W-1:0];
   assign rsp_port_ok = (32'(rsp_port) < NUM_REQS);
   assign axi.rready  = rsp_port_ok ? mem_rsp_ready[rsp_port] : 1'b1;

   generate
      for (genvar p = 0; p < NUM_REQS; p++) begin : g_rsp
         assign mem_rsp_valid[p] = axi.rvalid && rsp_port_ok && (rsp_port == PORT_W'(p));
         assign mem_rsp_tag[p]   = axi.rid[ID_WIDTH-1 -: TAG_WIDTH];
         assign mem_rsp_data[p]  = axi.rdata;
      end
   endgenerate

   assign rd_inc = req_fire && !req_is_wr;
   assign wr_inc = req_fire && req_is_wr;
   assign rd_dec = axi.rvalid && axi.rready;
   assign wr_dec = axi.bvalid;

   // Credits: simultaneous issue and retire cancel; a retire at zero never underflows
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_inc && !rd_dec) begin
            rd_cnt <= rd_cnt + CNT_ONE;
         end else if (rd_dec && !rd_inc && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - CNT_ONE;
         end
         if (wr_inc && !wr_dec) begin
            wr_cnt <= wr_cnt + CNT_ONE;
         end else if (wr_dec && !wr_inc && (wr_cnt != '0)) begin
            wr_cnt <= wr_cnt - CNT_ONE;
         end
      end
   end

   assign err_evt = (rd_dec && (axi.rresp != AXI_RESP_OKAY))
                  | (wr_dec && (axi.bresp != AXI_RESP_OKAY))
                  | (axi.rvalid && !rsp_port_ok)
                  | (rd_dec && (rd_cnt == '0))
                  | (wr_dec && (wr_cnt == '0));

   // Sticky error, cleared only by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         error <= 1'b0;
      end else if (err_evt) begin
         error <= 1'b1;
      end
   end

   assign busy = (rd_cnt != '0) || (wr_cnt != '0) || !iss_empty;

   // B carries no routing information and every transfer is single-beat
   assign unused_sigs = ^{axi.bid, axi.rlast};

endmodule : vx_axi_req_scheduler
`default_nettype wire

// File: tb/tb_vx_axi_req_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vx_axi_req_scheduler
// Description : Directed scoreboard bench for vx_axi_req_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_axi_req_scheduler;

   localparam int NR  = 2;
   localparam int DW  = 512;
   localparam int AWI = 26;
   localparam int AWO = 32;
   localparam int TW  = 8;
   localparam int MP  = 16;
   localparam int IDW = 9;
   localparam int SW  = DW / 8;

   typedef struct packed { logic [AWO-1:0] addr; logic [IDW-1:0] id; } addr_t;
   typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; } wbeat_t;
   typedef struct packed { logic [7:0] port; logic [TW-1:0] tag; logic [DW-1:0] data; } rsp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]  mem_req_valid, mem_req_rw, mem_req_ready;
   logic [AWI-1:0] mem_req_addr   [NR];
   logic [SW-1:0]  mem_req_byteen [NR];
   logic [DW-1:0]  mem_req_data   [NR];
   logic [TW-1:0]  mem_req_tag    [NR];
   logic [NR-1:0]  mem_rsp_valid, mem_rsp_ready;
   logic [DW-1:0]  mem_rsp_data   [NR];
   logic [TW-1:0]  mem_rsp_tag    [NR];
   logic           busy, error;

   vx_axi_req_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWO), .ID_WIDTH(IDW)) axi ();

   vx_axi_req_scheduler #(
      .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH_IN(AWI), .ADDR_WIDTH_OUT(AWO),
      .TAG_WIDTH(TW), .MAX_PENDING(MP), .ID_WIDTH(IDW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .mem_rsp_ready(mem_rsp_ready),
      .axi(axi), .busy(busy), .error(error)
   );

   int checks = 0;
   int errors = 0;

   addr_t  exp_ar[$];
   addr_t  exp_aw[$];
   wbeat_t exp_w[$];
   rsp_t   exp_rsp[$];

   addr_t  m_a;
   wbeat_t m_w;
   rsp_t   m_r;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input logic [31:0] x);
      return {16{x}};
   endfunction

   // Scoreboard monitor: every handshake seen on an output is matched to the oldest expectation
   always @(negedge clk) begin
      if (reset_n) begin
         if (axi.arvalid && axi.arready) begin
            if (exp_ar.size() == 0) begin
               checks++; errors++;
               $display("FAIL ar_unexpected: got addr %0h id %0h expected none", axi.araddr, axi.arid);
            end else begin
               m_a = exp_ar.pop_front();
               chk("araddr", axi.araddr, m_a.addr);
               chk("arid", axi.arid, m_a.id);
            end
         end
         if (axi.awvalid && axi.awready) begin
            if (exp_aw.size() == 0) begin
               checks++; errors++;
               $display("FAIL aw_unexpected: got addr %0h id %0h expected none", axi.awaddr, axi.awid);
            end else begin
               m_a = exp_aw.pop_front();
               chk("awaddr", axi.awaddr, m_a.addr);
               chk("awid", axi.awid, m_a.id);
            end
         end
         if (axi.wvalid && axi.wready) begin
            if (exp_w.size() == 0) begin
               checks++; errors++;
               $display("FAIL w_unexpected: got strb %0h expected none", axi.wstrb);
            end else begin
               m_w = exp_w.pop_front();
               chk("wdata", axi.wdata, m_w.data);
               chk("wstrb", axi.wstrb, m_w.strb);
            end
         end
         for (int p = 0; p < NR; p++) begin
            if (mem_rsp_valid[p] && mem_rsp_ready[p]) begin
               if (exp_rsp.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL rsp_unexpected: got port %0d tag %0h expected none", p, mem_rsp_tag[p]);
               end else begin
                  m_r = exp_rsp.pop_front();
                  chk("rsp_port", DW'(p), DW'(m_r.port));
                  chk("rsp_tag", mem_rsp_tag[p], m_r.tag);
                  chk("rsp_data", mem_rsp_data[p], m_r.data);
               end
            end
         end
      end
   end

   // Hold the current request of port p until it fires, then drop valid
   task automatic wait_fire(input int p);
      int n = 0;
      @(negedge clk);
      while (!mem_req_ready[p] && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!mem_req_ready[p]) begin
         checks++; errors++;
         $display("FAIL req_timeout: port %0d ready 0 expected 1", p);
      end
      @(posedge clk); #1;
      mem_req_valid[p] = 1'b0;
   endtask

   task automatic setup_req(input int p, input logic rw, input logic [AWI-1:0] a,
                            input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [SW-1:0] be);
      mem_req_rw[p]     = rw;
      mem_req_addr[p]   = a;
      mem_req_tag[p]    = t;
      mem_req_data[p]   = d;
      mem_req_byteen[p] = be;
      mem_req_valid[p]  = 1'b1;
   endtask

   task automatic req(input int p, input logic rw, input logic [AWI-1:0] a,
                      input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [SW-1:0] be);
      setup_req(p, rw, a, t, d, be);
      wait_fire(p);
   endtask

   // One R beat; the routed response is expected on the port named in the ID
   task automatic rbeat(input logic [IDW-1:0] id, input logic [1:0] resp, input logic [DW-1:0] d);
      int n = 0;
      rsp_t r;
      r.port = 8'(id[IDW-TW-1:0]);
      r.tag  = id[IDW-1 -: TW];
      r.data = d;
      exp_rsp.push_back(r);
      axi.rvalid = 1'b1; axi.rid = id; axi.rresp = resp; axi.rdata = d; axi.rlast = 1'b1;
      @(negedge clk);
      while (!axi.rready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!axi.rready) begin
         checks++; errors++;
         $display("FAIL rready_timeout: got 0 expected 1");
      end
      @(posedge clk); #1;
      axi.rvalid = 1'b0;
   endtask

   task automatic bbeat(input logic [IDW-1:0] id, input logic [1:0] resp);
      axi.bvalid = 1'b1; axi.bid = id; axi.bresp = resp;
      @(posedge clk); #1;
      axi.bvalid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fires;
      int n;
      mem_req_valid = '0; mem_req_rw = '0; mem_rsp_ready = '1;
      for (int p = 0; p < NR; p++) begin
         mem_req_addr[p] = '0; mem_req_byteen[p] = '0; mem_req_data[p] = '0; mem_req_tag[p] = '0;
      end
      axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
      axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
      axi.rvalid = 1'b0; axi.rid = '0; axi.rresp = '0; axi.rdata = '0; axi.rlast = 1'b0;

      // reset state and fixed burst attributes
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wvalid", axi.wvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_ready", mem_req_ready, 0);
      chk("arsize", axi.arsize, 6);
      chk("awsize", axi.awsize, 6);
      chk("arlen", axi.arlen, 0);
      chk("awburst", axi.awburst, 1);
      chk("wlast", axi.wlast, 1);
      chk("bready", axi.bready, 1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // single read from port 1
      exp_ar.push_back('{32'h400, 9'h0B5});
      req(1, 1'b0, 26'h10, 8'h5A, '0, '0);
      @(negedge clk);
      chk("t1_arvalid_lat1", axi.arvalid, 1);
      chk("t1_busy", busy, 1);
      @(posedge clk); #1;
      rbeat(9'h0B5, 2'b00, pat(32'hCAFE0001));
      @(negedge clk);
      chk("t1_busy_done", busy, 0);
      @(posedge clk); #1;

      // write with W delayed three cycles after AW; next request waits for W
      axi.wready = 1'b0;
      exp_aw.push_back('{32'hC0, 9'h044});
      exp_w.push_back('{pat(32'hDEAD0022), 64'hF0F0_F0F0_F0F0_F0F0});
      req(0, 1'b1, 26'h3, 8'h22, pat(32'hDEAD0022), 64'hF0F0_F0F0_F0F0_F0F0);
      exp_ar.push_back('{32'h800, 9'h023});
      setup_req(1, 1'b0, 26'h20, 8'h11, '0, '0);
      repeat (3) begin
         @(negedge clk);
         chk("t2_ready_blocked", mem_req_ready[1], 0);
      end
      @(posedge clk); #1;
      axi.wready = 1'b1;
      @(negedge clk);
      chk("t2_ready_blocked_w", mem_req_ready[1], 0);
      @(posedge clk); #1;
      wait_fire(1);
      @(negedge clk);
      chk("t2_wr_cnt_1", dut.wr_cnt, 1);
      @(posedge clk); #1;
      bbeat(9'h044, 2'b00);
      @(negedge clk);
      chk("t2_wr_cnt_0", dut.wr_cnt, 0);
      @(posedge clk); #1;
      rbeat(9'h023, 2'b00, pat(32'h0000B00B));

      // both ports reading continuously: grants alternate starting at port 0
      exp_ar.push_back('{32'h4000, 9'h060});
      exp_ar.push_back('{32'h4040, 9'h063});
      exp_ar.push_back('{32'h4000, 9'h060});
      exp_ar.push_back('{32'h4040, 9'h063});
      setup_req(0, 1'b0, 26'h100, 8'h30, '0, '0);
      setup_req(1, 1'b0, 26'h101, 8'h31, '0, '0);
      fires = 0;
      n = 0;
      while (fires < 4 && n < 100) begin
         @(negedge clk);
         n++;
         if (mem_req_ready != '0) begin
            chk("t3_grant_order", mem_req_ready, (fires % 2 == 0) ? 2'b01 : 2'b10);
            fires++;
            if (fires == 4) begin
               @(posedge clk); #1;
               mem_req_valid = '0;
            end
         end
      end
      if (fires < 4) begin
         checks++; errors++;
         $display("FAIL t3_timeout: got %0d fires expected 4", fires);
         mem_req_valid = '0;
      end
      chk("t3_rd_cnt", dut.rd_cnt, 4);
      rbeat(9'h060, 2'b00, pat(32'h30303030));
      rbeat(9'h063, 2'b00, pat(32'h31313131));
      rbeat(9'h060, 2'b00, pat(32'h30303031));
      rbeat(9'h063, 2'b00, pat(32'h31313132));
      @(negedge clk);
      chk("t3_busy_done", busy, 0);
      @(posedge clk); #1;

      // fill read credits; 17th read stalls while a write still goes through
      for (int i = 0; i < MP; i++) begin
         exp_ar.push_back('{AWO'((32'h200 + i) << 6), IDW'(i << 1)});
         req(0, 1'b0, AWI'(32'h200 + i), TW'(i), '0, '0);
      end
      exp_ar.push_back('{AWO'(32'h210 << 6), 9'h020});
      setup_req(0, 1'b0, 26'h210, 8'h10, '0, '0);
      repeat (3) begin
         @(negedge clk);
         chk("t4_read_full_blocked", mem_req_ready[0], 0);
      end
      @(posedge clk); #1;
      exp_aw.push_back('{32'h1540, 9'h0CD});
      exp_w.push_back('{pat(32'h12345678), {SW{1'b1}}});
      req(1, 1'b1, 26'h55, 8'h66, pat(32'h12345678), {SW{1'b1}});
      @(negedge clk);
      chk("t4_still_blocked", mem_req_ready[0], 0);
      chk("t4_wr_issued", dut.wr_cnt, 1);
      chk("t4_rd_cnt_full", dut.rd_cnt, 16);
      @(posedge clk); #1;
      rbeat(9'h000, 2'b00, pat(32'h20000000));
      wait_fire(0);
      bbeat(9'h0CD, 2'b00);
      for (int i = 1; i <= MP; i++) begin
         rbeat(IDW'(i << 1), 2'b00, pat(32'h20000000 + i));
      end
      @(negedge clk);
      chk("t4_busy_done", busy, 0);
      chk("t4_error_clean", error, 0);
      @(posedge clk); #1;

      // error response is sticky
      exp_ar.push_back('{32'h1DC0, 9'h0EE});
      req(0, 1'b0, 26'h77, 8'h77, '0, '0);
      rbeat(9'h0EE, 2'b10, pat(32'hBAD00077));
      @(negedge clk);
      chk("t5_error_set", error, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t5_error_sticky", error, 1);
      chk("t5_rd_cnt", dut.rd_cnt, 0);
      @(posedge clk); #1;

      // reset mid-transaction with rd_cnt=3 and arvalid pending
      exp_ar.push_back('{32'hC000, 9'h080});
      req(0, 1'b0, 26'h300, 8'h40, '0, '0);
      exp_ar.push_back('{32'hC040, 9'h082});
      req(0, 1'b0, 26'h301, 8'h41, '0, '0);
      @(posedge clk); #1;
      axi.arready = 1'b0;
      req(0, 1'b0, 26'h302, 8'h42, '0, '0);
      @(negedge clk);
      chk("t6_arvalid_pending", axi.arvalid, 1);
      chk("t6_rd_cnt_3", dut.rd_cnt, 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_arvalid", axi.arvalid, 0);
      chk("t6_rst_rd_cnt", dut.rd_cnt, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_error", error, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      axi.arready = 1'b1;
      rbeat(9'h084, 2'b00, pat(32'h57A1E000));
      @(negedge clk);
      chk("t6_stale_error", error, 1);
      chk("t6_stale_rd_cnt", dut.rd_cnt, 0);

      chk("queues_empty", DW'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_rsp.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_vx_axi_req_scheduler
`default_nettype wire

// File: doc/vx_axi_req_scheduler.md
Name: vx_axi_req_scheduler

Overview:
- Shares one AXI4 master port between NUM_REQS Vortex memory-request ports, using round-robin arbitration.
- Sequences the AW/W/AR channels through a one-entry issue register and caps in-flight reads and writes with credit counters.
- Routes R responses back to the originating port using the port index carried in the AXI ID.
- Sits between the per-port mem data adapters and an AXI bank, in place of a direct port-to-bank connection.

Parameters:
- NUM_REQS, 2: number of requesting memory ports.
- DATA_WIDTH, 512: data width in bits, identical on both sides.
- ADDR_WIDTH_IN, 26: block (line) address width on the request side.
- ADDR_WIDTH_OUT, 32: AXI byte address width.
- TAG_WIDTH, 8: request tag width.
- MAX_PENDING, 16: maximum outstanding reads, and separately the maximum outstanding writes.
- ID_WIDTH, TAG_WIDTH+CLOG2(NUM_REQS): AXI ID width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- mem_req_valid  in  [NUM_REQS]x1  request valid
- mem_req_rw  in  [NUM_REQS]x1  1=write
- mem_req_addr  in  [NUM_REQS]xADDR_WIDTH_IN  line address
- mem_req_byteen  in  [NUM_REQS]xDATA_WIDTH/8  write byte enables
- mem_req_data  in  [NUM_REQS]xDATA_WIDTH  write data
- mem_req_tag  in  [NUM_REQS]xTAG_WIDTH  tag
- mem_req_ready  out  [NUM_REQS]x1  request accepted
- mem_rsp_valid  out  [NUM_REQS]x1  read response valid
- mem_rsp_data  out  [NUM_REQS]xDATA_WIDTH  read data
- mem_rsp_tag  out  [NUM_REQS]xTAG_WIDTH  response tag
- mem_rsp_ready  in  [NUM_REQS]x1  response accepted
- m_axi_awvalid/awready/awaddr/awid  out/in/out/out  1/1/ADDR_WIDTH_OUT/ID_WIDTH  write address channel
- m_axi_awlen/awsize/awburst  out  8/3/2  write burst attributes
- m_axi_wvalid/wready/wdata/wstrb/wlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- m_axi_bvalid/bready/bid/bresp  in/out/in/in  1/1/ID_WIDTH/2  write response channel
- m_axi_arvalid/arready/araddr/arid  out/in/out/out  1/1/ADDR_WIDTH_OUT/ID_WIDTH  read address channel
- m_axi_arlen/arsize/arburst  out  8/3/2  read burst attributes
- m_axi_rvalid/rready/rdata/rid/rresp/rlast  in/out/in/in/in/in  1/1/DATA_WIDTH/ID_WIDTH/2/1  read data channel
- busy  out  1  any request in flight
- error  out  1  sticky error flag

Behaviour:
- Clocking and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset state: all registered valids are 0, rd_cnt=wr_cnt=0, rr pointer=0, error=0, issue register empty.
- Fixed burst attributes: awlen=arlen=0, awsize=arsize=CLOG2(DATA_WIDTH/8), awburst=arburst=2'b01, wlast=1.

Arbitration:
- Eligible port i: mem_req_valid[i], and its counter is below MAX_PENDING (rd_cnt for reads, wr_cnt for writes).
- The grant goes to the first eligible port searching from rr+1 (mod NUM_REQS).
- mem_req_ready[i] = grant[i] and the issue register is empty. It depends combinationally on valid; there is no valid-on-ready dependency in the reverse direction.
- On fire: rr <= i, the issue register loads, and the matching counter increments.
- A full counter blocks only requests of that type. A full counter is not bypassed by a response retiring in the same cycle.

Issue register:
- Loads are registered: the AXI valid rises the cycle after mem request fire (latency 1).
- Write: awvalid and wvalid are both set. Each clears independently on its own handshake. The register empties when both are clear, including when both handshake in the same cycle.
- Read: arvalid is set and clears on arready.
- A refill can fire in the cycle after the register empties, not in the same cycle.
- Address: {addr, CLOG2(DATA_WIDTH/8) zero bits}, zero-extended or truncated to ADDR_WIDTH_OUT.
- ID: {tag, port index}.

Responses:
- rready = mem_rsp_ready[rid port field].
- mem_rsp_valid[p] = rvalid when the port field equals p. Tag is rid[ID_WIDTH-1 -: TAG_WIDTH]; data is passed through.
- rd_cnt decrements on the R handshake.
- bready is held at 1. wr_cnt decrements on bvalid. Writes produce no mem response.
- Issue and retire of the same type in the same cycle leave the counter unchanged.

Error and boundary conditions:
- error is set on rresp!=0 or bresp!=0.
- error is set on a retire with counter==0. In that case the counter stays at 0 and never underflows.
- An rid port field >= NUM_REQS sets error and the beat is dropped with rready=1.
- busy = (rd_cnt!=0) | (wr_cnt!=0) | issue register non-empty.
- Reset mid-transaction clears all state immediately. Responses that arrive later are handled by the counter==0 rule.

Decomposition:
- Shared package: the AXI burst/size constants and the ID pack/unpack widths (port-field width CLOG2(NUM_REQS)).
- Sub-module: vx_rr_grant, a round-robin grant with a registered pointer and NUM_REQS parameter, reusable elsewhere.
- The counters and issue register stay in the top level.

Test Plan:
- Single read from port 1, addr=0x10, tag=0x5A: arvalid at cycle+1, araddr=0x400, arid={0x5A,1}; R with rid={0x5A,1} gives mem_rsp_valid[1]=1, tag=0x5A; busy returns to 0.
- Write with wready delayed 3 cycles after awready: mem_req_ready stays low for the next request until the W handshake; wr_cnt=1 until bvalid, then 0.
- Both ports continuously valid reading: grants alternate 0,1,0,1; four issues yield two per port.
- 16 reads with no R responses: the 17th read is stalled (ready=0) while a write from the other port still issues; one R response allows the 17th read to issue on a following cycle.
- rresp=2'b10 on a response: error=1 and stays 1 until reset_n=0.
- Assert reset_n low with arvalid=1 and rd_cnt=3: arvalid=0, rd_cnt=0 and busy=0 immediately; a stale R response sets error and rd_cnt stays 0.
